// File: rtl/rst_ce_sequencer_if.sv
// Control/status bundle between a sequencer and the logic that requests enables.
// STALL exists only when RST_CE_SEQ_STALL_EN is defined.
interface rst_ce_sequencer_if #(
    parameter int DIV_WIDTH = 8
);
    logic                 RUN;
    logic [DIV_WIDTH-1:0] DIV;
`ifdef RST_CE_SEQ_STALL_EN
    logic                 STALL;
`endif
    logic                 RN;
    logic                 E;
    logic                 READY;
    logic [15:0]          ENCNT;

`ifdef RST_CE_SEQ_STALL_EN
    modport master (output RUN, output DIV, output STALL,
                    input RN, input E, input READY, input ENCNT);
    modport slave  (input RUN, input DIV, input STALL,
                    output RN, output E, output READY, output ENCNT);
`else
    modport master (output RUN, output DIV,
                    input RN, input E, input READY, input ENCNT);
    modport slave  (input RUN, input DIV,
                    output RN, output E, output READY, output ENCNT);
`endif
endinterface

// File: rtl/rst_ce_sequencer.sv
// Reset synchronizer plus hold-off and programmable clock-enable generator for DFFRE banks.
// Optional STALL input enabled by defining RST_CE_SEQ_STALL_EN.
//
//  state  | meaning
//  SYNC   | reset released, shifting ones through the deassertion synchronizer
//  HOLD   | RN high, waiting HOLDOFF cycles before enables are allowed
//  ACTIVE | READY high, divider issues E pulses while RUN is set
module rst_ce_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLDOFF     = 4,
    parameter int DIV_WIDTH   = 8
) (
    input logic              C,
    input logic              R,
    rst_ce_sequencer_if.slave bus
);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        HOLD   = 2'd1,
        ACTIVE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [HW-1:0]        hold_q, hold_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic                 e_q, e_d;
    logic                 ready_q, ready_d;
    logic [15:0]          encnt_q, encnt_d;
    logic                 stall;

`ifdef RST_CE_SEQ_STALL_EN
    assign stall = bus.STALL;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge C or posedge R) begin
        if (R) begin
            state_q <= SYNC;
            sync_q  <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
            e_q     <= 1'b0;
            ready_q <= 1'b0;
            encnt_q <= '0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            e_q     <= e_d;
            ready_q <= ready_d;
            encnt_q <= encnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        e_d     = 1'b0;
        encnt_d = encnt_q;
        case (state_q)
            SYNC: begin
                // leave SYNC on the same edge that drives RN high
                if (sync_q[SYNC_STAGES-2]) begin
                    if (HOLDOFF == 0) begin
                        state_d = ACTIVE;
                    end else begin
                        state_d = HOLD;
                        hold_d  = HOLD_LOAD;
                    end
                end
            end
            HOLD: begin
                if (hold_q == '0) state_d = ACTIVE;
                else              hold_d  = hold_q - HW'(1);
            end
            ACTIVE: begin
                if (!stall) begin
                    if (!bus.RUN) begin
                        cnt_d = '0;
                    end else if (cnt_q == '0) begin
                        e_d     = 1'b1;
                        cnt_d   = bus.DIV;
                        encnt_d = encnt_q + 16'd1;
                    end else begin
                        cnt_d = cnt_q - DIV_WIDTH'(1);
                    end
                end
            end
            default: state_d = SYNC;
        endcase
        ready_d = (state_d == ACTIVE);
    end

    assign bus.RN    = sync_q[SYNC_STAGES-1];
    assign bus.E     = e_q;
    assign bus.READY = ready_q;
    assign bus.ENCNT = encnt_q;
endmodule

// File: tb/tb_rst_ce_sequencer.sv
// Directed bench for rst_ce_sequencer with default parameters.
module tb_rst_ce_sequencer;
    logic C;
    logic R;
    int   n_checks = 0;
    int   n_errors = 0;

    rst_ce_sequencer_if #(.DIV_WIDTH(8)) bus ();

    rst_ce_sequencer #(
        .SYNC_STAGES(2),
        .HOLDOFF    (4),
        .DIV_WIDTH  (8)
    ) dut (
        .C  (C),
        .R  (R),
        .bus(bus.slave)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge C);
        @(negedge C);
    endtask

    // Assert R, set inputs, and release at a falling edge so the next rising edge is edge 1.
    task automatic restart(input logic run, input logic [7:0] div);
        R = 1'b1;
        bus.RUN = run;
        bus.DIV = div;
`ifdef RST_CE_SEQ_STALL_EN
        bus.STALL = 1'b0;
`endif
        step();
        R = 1'b0;
    endtask

    task automatic check_startup(input string tag);
        for (int k = 1; k <= 9; k++) begin
            step();
            check($sformatf("%s_rn_e%0d", tag, k), 32'(bus.RN), 32'(k >= 2));
            check($sformatf("%s_ready_e%0d", tag, k), 32'(bus.READY), 32'(k >= 6));
            check($sformatf("%s_e_e%0d", tag, k), 32'(bus.E), 32'(k >= 7));
            check($sformatf("%s_encnt_e%0d", tag, k), 32'(bus.ENCNT), (k >= 7) ? 32'(k - 6) : 32'd0);
        end
    endtask

    initial begin
        int gaps;
        R = 1'b1;
        bus.RUN = 1'b0;
        bus.DIV = '0;
`ifdef RST_CE_SEQ_STALL_EN
        bus.STALL = 1'b0;
`endif
        #2;
        check("rst_rn", 32'(bus.RN), 32'd0);
        check("rst_e", 32'(bus.E), 32'd0);
        check("rst_ready", 32'(bus.READY), 32'd0);
        check("rst_encnt", 32'(bus.ENCNT), 32'd0);

        // Startup timing with DIV=0
        @(negedge C);
        bus.RUN = 1'b1;
        bus.DIV = 8'd0;
        R = 1'b0;
        check_startup("t1");

        // Async reset pulse between edges while ACTIVE, then identical restart
        #1 R = 1'b1;
        #1;
        check("t4_rn", 32'(bus.RN), 32'd0);
        check("t4_e", 32'(bus.E), 32'd0);
        check("t4_ready", 32'(bus.READY), 32'd0);
        check("t4_encnt", 32'(bus.ENCNT), 32'd0);
        #1 R = 1'b0;
        check_startup("t4");

        // DIV=2: E after edges 7, 10, 13
        restart(1'b1, 8'd2);
        for (int k = 1; k <= 13; k++) begin
            step();
            check($sformatf("t2_e_e%0d", k), 32'(bus.E), 32'(k == 7 || k == 10 || k == 13));
        end
        check("t2_encnt", 32'(bus.ENCNT), 32'd3);

        // DIV=3, RUN dropped for edges 9..13, restored from edge 14
        restart(1'b1, 8'd3);
        for (int k = 1; k <= 18; k++) begin
            step();
            if (k >= 7)
                check($sformatf("t3_e_e%0d", k), 32'(bus.E), 32'(k == 7 || k == 14 || k == 18));
            if (k == 8)  bus.RUN = 1'b0;
            if (k == 13) bus.RUN = 1'b1;
        end
        check("t3_encnt", 32'(bus.ENCNT), 32'd3);

        // ENCNT wrap with continuous enables
        restart(1'b1, 8'd0);
        for (int k = 1; k <= 7; k++) step();
        check("t5_encnt_first", 32'(bus.ENCNT), 32'd1);
        gaps = 0;
        for (int n = 2; n <= 65535; n++) begin
            step();
            if (bus.E !== 1'b1) gaps++;
        end
        check("t5_encnt_max", 32'(bus.ENCNT), 32'h0000_FFFF);
        step();
        check("t5_encnt_wrap", 32'(bus.ENCNT), 32'd0);
        check("t5_e_wrap", 32'(bus.E), 32'd1);
        check("t5_gaps", 32'(gaps), 32'd0);

`ifdef RST_CE_SEQ_STALL_EN
        // DIV=3, STALL on edges 8..10: next E moves from edge 11 to edge 14
        restart(1'b1, 8'd3);
        for (int k = 1; k <= 14; k++) begin
            step();
            if (k >= 7) begin
                check($sformatf("t6_e_e%0d", k), 32'(bus.E), 32'(k == 7 || k == 14));
                check($sformatf("t6_encnt_e%0d", k), 32'(bus.ENCNT), (k == 14) ? 32'd2 : 32'd1);
            end
            if (k == 7)  bus.STALL = 1'b1;
            if (k == 10) bus.STALL = 1'b0;
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
